sub3_serial: RTL



---
 rtl/sub3_pkg.sv | 13 +
 rtl/sub3_if.sv | 28 ++
 rtl/sub3_bit_cell.sv | 27 ++
 rtl/sub3_serial.sv | 105 ++++++++++
 4 files changed

// File: rtl/sub3_pkg.sv
// rtl/sub3_pkg.sv - shared types and constants for the bit-serial three-operand subtractor
package sub3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BORROW_W   = 2;
    localparam int MAX_BORROW = 2;

endpackage

// File: rtl/sub3_if.sv
// rtl/sub3_if.sv - operand/result handshake bundle for sub3_serial
interface sub3_if
    import sub3_pkg::*;
#(
    parameter int WIDTH = 4
);

    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_sum;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_diff;
    logic [BORROW_W-1:0] out_borrow;

    modport master (
        output in_valid, in_sum, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow
    );

    modport slave (
        input  in_valid, in_sum, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_borrow
    );

endinterface

// File: rtl/sub3_bit_cell.sv
// rtl/sub3_bit_cell.sv - one-bit s - a - b - borrow cell with a two-bit borrow out
module sub3_bit_cell
    import sub3_pkg::*;
(
    input  logic                s,
    input  logic                a,
    input  logic                b,
    input  logic [BORROW_W-1:0] br_in,
    output logic                d,
    output logic [BORROW_W-1:0] br_out
);

    logic [3:0] v;
    logic [3:0] t;
    logic       unused_t;

    // v is the signed column value (-4..1) held mod 16; t = d - v is always 0..4 and even.
    always_comb begin
        v      = {3'b000, s} - {3'b000, a} - {3'b000, b} - {2'b00, br_in};
        d      = v[0];
        t      = {3'b000, v[0]} - v;
        br_out = t[2:1];
    end

    assign unused_t = ^{t[3], t[0]};

endmodule

// File: rtl/sub3_serial.sv
// rtl/sub3_serial.sv - bit-serial diff = sum - a - b with wrap count, LSB first
module sub3_serial
    import sub3_pkg::*;
#(
    parameter int WIDTH = 4
)(
    input  logic clk,
    input  logic rst_n,
    sub3_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t              state_q;
    state_t              state_n;
    logic [WIDTH-1:0]    sum_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    res_q;
    logic [BORROW_W-1:0] br_q;
    logic [BORROW_W-1:0] br_next;
    logic [CNT_W-1:0]    cnt_q;
    logic                d_bit;
    logic                accept;
    logic                last_bit;
    logic                in_ready_c;
    logic                out_valid_c;

    sub3_bit_cell u_cell (
        .s      (sum_q[0]),
        .a      (a_q[0]),
        .b      (b_q[0]),
        .br_in  (br_q),
        .d      (d_bit),
        .br_out (br_next)
    );

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            br_q  <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            sum_q <= bus.in_sum;
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            br_q  <= '0;
            cnt_q <= '0;
        end else if (state_q == BUSY) begin
            sum_q <= sum_q >> 1;
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            res_q <= {d_bit, res_q[WIDTH-1:1]};
            br_q  <= br_next;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.out_diff   = res_q;
    assign bus.out_borrow = br_q;

endmodule
